dc_alu_reg: RTL and testbench

//  Decode->ALU pipeline register; includes load-use hazard detection.

---
 rtl/dc_alu_reg_pkg.sv | 44 ++++
 rtl/dc_alu_hazard.sv | 22 ++
 rtl/dc_alu_reg.sv | 144 ++++++++++++++
 tb/tb_dc_alu_reg.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/dc_alu_reg_pkg.sv
// Shared widths, payload struct and helpers for the decode->ALU pipeline register.
// The bubble opcode and the field layout live here so the top and the hazard unit agree.
package dc_alu_reg_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned ALU_OP_W   = 4;
  localparam int unsigned PERF_W     = 32;

  localparam logic [ALU_OP_W-1:0] ALU_OP_NOP = ALU_OP_W'(0);

  typedef struct packed {
    logic [XLEN-1:0]       pc;
    logic [REG_ADDR_W-1:0] rs1_addr;
    logic [REG_ADDR_W-1:0] rs2_addr;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic [XLEN-1:0]       rs1_data;
    logic [XLEN-1:0]       rs2_data;
    logic [XLEN-1:0]       imm;
    logic [ALU_OP_W-1:0]   alu_op;
    logic                  mem_read;
    logic                  mem_write;
    logic                  reg_write;
  } dc_fields_t;

  typedef enum logic [1:0] {
    UPD_HOLD    = 2'd0,
    UPD_BUBBLE  = 2'd1,
    UPD_CAPTURE = 2'd2
  } upd_e;

  // All-zero slot: no addresses, no writes, NOP opcode.
  function automatic dc_fields_t bubble();
    dc_fields_t b;
    b        = '0;
    b.alu_op = ALU_OP_NOP;
    return b;
  endfunction

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (v == {PERF_W{1'b1}}) ? v : v + PERF_W'(1);
  endfunction

endpackage

// File: rtl/dc_alu_hazard.sv
// Combinational load-use detector; derives the decode back-pressure signal.
module dc_alu_hazard
  import dc_alu_reg_pkg::*;
(
  input  logic                  ex_valid,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic                  mem_stall,
  output logic                  load_use_c,
  output logic                  id_ready_c
);

  // x0 is hardwired zero, so a load targeting it can never create a dependency.
  assign load_use_c = ex_valid & ex_mem_read & (ex_rd_addr != REG_ADDR_W'(0)) & id_valid &
                      ((id_rs1_addr == ex_rd_addr) | (id_rs2_addr == ex_rd_addr));

  assign id_ready_c = !mem_stall & !load_use_c;

endmodule

// File: rtl/dc_alu_reg.sv
// Decode->ALU pipeline register with load-use bubble insertion, flush and stall hold.
// Optional DC_ALU_PERF_CNT_EN adds saturating stall/bubble/flush counters.
module dc_alu_reg
  import dc_alu_reg_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [XLEN-1:0]       id_pc,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic [REG_ADDR_W-1:0] id_rd_addr,
  input  logic [XLEN-1:0]       id_rs1_data,
  input  logic [XLEN-1:0]       id_rs2_data,
  input  logic [XLEN-1:0]       id_imm,
  input  logic [ALU_OP_W-1:0]   id_alu_op,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  id_reg_write,
  input  logic                  mem_stall,
  input  logic                  flush,
  output logic                  id_ready,
  output logic                  ex_valid,
  output logic [XLEN-1:0]       ex_pc,
  output logic [REG_ADDR_W-1:0] ex_rs1_addr,
  output logic [REG_ADDR_W-1:0] ex_rs2_addr,
  output logic [REG_ADDR_W-1:0] ex_rd_addr,
  output logic [XLEN-1:0]       ex_rs1_data,
  output logic [XLEN-1:0]       ex_rs2_data,
  output logic [XLEN-1:0]       ex_imm,
  output logic [ALU_OP_W-1:0]   ex_alu_op,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_reg_write
`ifdef DC_ALU_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0]     perf_stall_cnt,
  output logic [PERF_W-1:0]     perf_bubble_cnt,
  output logic [PERF_W-1:0]     perf_flush_cnt
`endif
);

  dc_fields_t id_f;
  dc_fields_t ex_q;
  logic       ex_valid_q;
  logic       load_use;
  upd_e       upd;

  always_comb begin
    id_f           = '0;
    id_f.pc        = id_pc;
    id_f.rs1_addr  = id_rs1_addr;
    id_f.rs2_addr  = id_rs2_addr;
    id_f.rd_addr   = id_rd_addr;
    id_f.rs1_data  = id_rs1_data;
    id_f.rs2_data  = id_rs2_data;
    id_f.imm       = id_imm;
    id_f.alu_op    = id_alu_op;
    id_f.mem_read  = id_mem_read;
    id_f.mem_write = id_mem_write;
    id_f.reg_write = id_reg_write;
  end

  dc_alu_hazard u_hazard (
    .ex_valid    (ex_valid_q),
    .ex_mem_read (ex_q.mem_read),
    .ex_rd_addr  (ex_q.rd_addr),
    .id_valid    (id_valid),
    .id_rs1_addr (id_rs1_addr),
    .id_rs2_addr (id_rs2_addr),
    .mem_stall   (mem_stall),
    .load_use_c  (load_use),
    .id_ready_c  (id_ready)
  );

  // Stall beats flush (flush source keeps it asserted), flush beats load-use.
  always_comb begin
    upd = UPD_BUBBLE;
    if (mem_stall) begin
      upd = UPD_HOLD;
    end else if (flush || load_use) begin
      upd = UPD_BUBBLE;
    end else if (id_valid) begin
      upd = UPD_CAPTURE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q       <= bubble();
      ex_valid_q <= 1'b0;
    end else begin
      case (upd)
        UPD_CAPTURE: begin
          ex_q       <= id_f;
          ex_valid_q <= 1'b1;
        end
        UPD_BUBBLE: begin
          ex_q       <= bubble();
          ex_valid_q <= 1'b0;
        end
        default: begin
          ex_q       <= ex_q;
          ex_valid_q <= ex_valid_q;
        end
      endcase
    end
  end

  assign ex_valid     = ex_valid_q;
  assign ex_pc        = ex_q.pc;
  assign ex_rs1_addr  = ex_q.rs1_addr;
  assign ex_rs2_addr  = ex_q.rs2_addr;
  assign ex_rd_addr   = ex_q.rd_addr;
  assign ex_rs1_data  = ex_q.rs1_data;
  assign ex_rs2_data  = ex_q.rs2_data;
  assign ex_imm       = ex_q.imm;
  assign ex_alu_op    = ex_q.alu_op;
  assign ex_mem_read  = ex_q.mem_read;
  assign ex_mem_write = ex_q.mem_write;
  assign ex_reg_write = ex_q.reg_write;

`ifdef DC_ALU_PERF_CNT_EN
  // Bubble counter only sees load-use bubbles that actually reach the register.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt  <= PERF_W'(0);
      perf_bubble_cnt <= PERF_W'(0);
      perf_flush_cnt  <= PERF_W'(0);
    end else begin
      if (mem_stall) begin
        perf_stall_cnt <= sat_inc(perf_stall_cnt);
      end
      if (!mem_stall && !flush && load_use) begin
        perf_bubble_cnt <= sat_inc(perf_bubble_cnt);
      end
      if (!mem_stall && flush) begin
        perf_flush_cnt <= sat_inc(perf_flush_cnt);
      end
    end
  end
`endif

endmodule

// File: tb/tb_dc_alu_reg.sv
// Self-checking bench for dc_alu_reg: per-cycle vector table with a scoreboard of ex_* results.
module tb_dc_alu_reg;
  import dc_alu_reg_pkg::*;

  typedef enum logic [1:0] {K_CAP, K_BUB, K_HOLD} kind_e;

  typedef struct {
    logic       rst;
    logic       idv;
    logic       stall;
    logic       flush;
    dc_fields_t f;
    kind_e      kind;
    logic       rdy;
  } vec_t;

  typedef struct packed {
    logic       valid;
    dc_fields_t f;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  id_valid = 1'b0;
  logic [XLEN-1:0]       id_pc = '0;
  logic [REG_ADDR_W-1:0] id_rs1_addr = '0;
  logic [REG_ADDR_W-1:0] id_rs2_addr = '0;
  logic [REG_ADDR_W-1:0] id_rd_addr = '0;
  logic [XLEN-1:0]       id_rs1_data = '0;
  logic [XLEN-1:0]       id_rs2_data = '0;
  logic [XLEN-1:0]       id_imm = '0;
  logic [ALU_OP_W-1:0]   id_alu_op = '0;
  logic                  id_mem_read = 1'b0;
  logic                  id_mem_write = 1'b0;
  logic                  id_reg_write = 1'b0;
  logic                  mem_stall = 1'b0;
  logic                  flush = 1'b0;
  logic                  id_ready;
  logic                  ex_valid;
  logic [XLEN-1:0]       ex_pc;
  logic [REG_ADDR_W-1:0] ex_rs1_addr;
  logic [REG_ADDR_W-1:0] ex_rs2_addr;
  logic [REG_ADDR_W-1:0] ex_rd_addr;
  logic [XLEN-1:0]       ex_rs1_data;
  logic [XLEN-1:0]       ex_rs2_data;
  logic [XLEN-1:0]       ex_imm;
  logic [ALU_OP_W-1:0]   ex_alu_op;
  logic                  ex_mem_read;
  logic                  ex_mem_write;
  logic                  ex_reg_write;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dc_alu_reg dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_alu_op(id_alu_op), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_reg_write(id_reg_write), .mem_stall(mem_stall), .flush(flush),
    .id_ready(id_ready), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr), .ex_rd_addr(ex_rd_addr),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_alu_op(ex_alu_op), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_reg_write(ex_reg_write)
  );

  function automatic dc_fields_t fld(input logic [31:0] pc, input logic [4:0] rs1,
                                     input logic [4:0] rs2, input logic [4:0] rd,
                                     input logic [31:0] d1, input logic [31:0] d2,
                                     input logic [31:0] imm, input logic [3:0] op,
                                     input logic mr, input logic mw, input logic rw);
    dc_fields_t r;
    r = '{pc: pc, rs1_addr: rs1, rs2_addr: rs2, rd_addr: rd, rs1_data: d1,
          rs2_data: d2, imm: imm, alu_op: op, mem_read: mr, mem_write: mw, reg_write: rw};
    return r;
  endfunction

  function automatic vec_t v(input logic r, input logic idv, input logic st, input logic fl,
                             input dc_fields_t f, input kind_e k, input logic rdy);
    vec_t x;
    x = '{rst: r, idv: idv, stall: st, flush: fl, f: f, kind: k, rdy: rdy};
    return x;
  endfunction

  vec_t       vecs[$];
  exp_t       sb[$];
  exp_t       last_exp;
  exp_t       exp_v;
  exp_t       got;
  dc_fields_t z, dep, st_f, fl_f, g_f, m_f;

  initial begin
    z    = '0;
    dep  = fld(32'h108, 5'd7, 5'd2, 5'd8, 32'h33, 32'h44, 32'h0, 4'd3, 1'b0, 1'b0, 1'b1);
    st_f = fld(32'h11c, 5'd3, 5'd3, 5'd11, 32'h1, 32'h2, 32'h3, 4'd6, 1'b0, 1'b0, 1'b1);
    fl_f = fld(32'h128, 5'd13, 5'd0, 5'd14, 32'h99, 32'h0, 32'h0, 4'd2, 1'b0, 1'b0, 1'b1);
    g_f  = fld(32'h130, 5'd14, 5'd14, 5'd15, 32'h5, 32'h6, 32'h0, 4'd1, 1'b0, 1'b0, 1'b1);
    m_f  = fld(32'h138, 5'd4, 5'd5, 5'd17, 32'hdead, 32'hbeef, 32'h10, 4'd7, 1'b0, 1'b0, 1'b1);

    // Reset for two cycles
    vecs.push_back(v(1'b1, 1'b0, 1'b0, 1'b0, z, K_BUB, 1'b1));
    vecs.push_back(v(1'b1, 1'b0, 1'b0, 1'b0, z, K_BUB, 1'b1));
    // Basic capture
    vecs.push_back(v(1'b0, 1'b1, 1'b0, 1'b0,
      fld(32'h100, 5'd3, 5'd4, 5'd5, 32'h11, 32'h22, 32'h7, 4'd2, 1'b0, 1'b0, 1'b1), K_CAP, 1'b1));
    // Load rd=7, then rs1 dependent: one bubble, then capture
    vecs.push_back(v(1'b0, 1'b1, 1'b0, 1'b0,
      fld(32'h104, 5'd1, 5'd0, 5'd7, 32'h1000, 32'h0, 32'h4, 4'd1, 1'b1, 1'b0, 1'b1), K_CAP, 1'b1));
    vecs.push_back(v(1'b0, 1'b1, 1'b0, 1'b0, dep, K_BUB, 1'b0));
    vecs.push_back(v(1'b0, 1'b1, 1'b0, 1'b0, dep, K_CAP, 1'b1));
    // Load rd=0 followed by a reader of x0: no hazard
    vecs.push_back(v(1'b0, 1'b1, 1'b0, 1'b0,
      fld(32'h10c, 5'd2, 5'd0, 5'd0, 32'h55, 32'h0, 32'h8, 4'd1, 1'b1, 1'b0, 1'b1), K_CAP, 1'b1));
    vecs.push_back(v(1'b0, 1'b1, 1'b0, 1'b0,
      fld(32'h110, 5'd0, 5'd0, 5'd6, 32'h0, 32'h0, 32'h0, 4'd4, 1'b0, 1'b0, 1'b1), K_CAP, 1'b1));
    // Load rd=10, then rs2 dependent store
    vecs.push_back(v(1'b0, 1'b1, 1'b0, 1'b0,
      fld(32'h114, 5'd6, 5'd0, 5'd10, 32'h66, 32'h0, 32'hc, 4'd1, 1'b1, 1'b0, 1'b1), K_CAP, 1'b1));
    vecs.push_back(v(1'b0, 1'b1, 1'b0, 1'b0,
      fld(32'h118, 5'd1, 5'd10, 5'd12, 32'h77, 32'h88, 32'h0, 4'd5, 1'b0, 1'b1, 1'b0), K_BUB, 1'b0));
    vecs.push_back(v(1'b0, 1'b1, 1'b0, 1'b0,
      fld(32'h118, 5'd1, 5'd10, 5'd12, 32'h77, 32'h88, 32'h0, 4'd5, 1'b0, 1'b1, 1'b0), K_CAP, 1'b1));
    // Three stall cycles, flush arriving during stall, applied on release
    vecs.push_back(v(1'b0, 1'b1, 1'b1, 1'b0, st_f, K_HOLD, 1'b0));
    vecs.push_back(v(1'b0, 1'b1, 1'b1, 1'b1, st_f, K_HOLD, 1'b0));
    vecs.push_back(v(1'b0, 1'b1, 1'b1, 1'b1, st_f, K_HOLD, 1'b0));
    vecs.push_back(v(1'b0, 1'b1, 1'b0, 1'b1, st_f, K_BUB, 1'b1));
    // Flush kills a valid rd=9 writer
    vecs.push_back(v(1'b0, 1'b1, 1'b0, 1'b1,
      fld(32'h120, 5'd1, 5'd2, 5'd9, 32'h12, 32'h34, 32'h0, 4'd2, 1'b0, 1'b0, 1'b1), K_BUB, 1'b1));
    // Flush together with load-use: bubble, id_ready still low
    vecs.push_back(v(1'b0, 1'b1, 1'b0, 1'b0,
      fld(32'h124, 5'd1, 5'd0, 5'd13, 32'h21, 32'h0, 32'h0, 4'd1, 1'b1, 1'b0, 1'b1), K_CAP, 1'b1));
    vecs.push_back(v(1'b0, 1'b1, 1'b0, 1'b1, fl_f, K_BUB, 1'b0));
    vecs.push_back(v(1'b0, 1'b1, 1'b0, 1'b0, fl_f, K_CAP, 1'b1));
    // Matching addresses but id_valid low: no hazard
    vecs.push_back(v(1'b0, 1'b1, 1'b0, 1'b0,
      fld(32'h12c, 5'd2, 5'd0, 5'd14, 32'h9, 32'h0, 32'h0, 4'd1, 1'b1, 1'b0, 1'b1), K_CAP, 1'b1));
    vecs.push_back(v(1'b0, 1'b0, 1'b0, 1'b0, g_f, K_BUB, 1'b1));
    // Reset in the middle of a stall
    vecs.push_back(v(1'b0, 1'b1, 1'b0, 1'b0, m_f, K_CAP, 1'b1));
    vecs.push_back(v(1'b0, 1'b1, 1'b1, 1'b0, m_f, K_HOLD, 1'b0));
    vecs.push_back(v(1'b1, 1'b1, 1'b1, 1'b0, m_f, K_BUB, 1'b0));
    vecs.push_back(v(1'b0, 1'b0, 1'b0, 1'b0, z, K_BUB, 1'b1));

    last_exp = '0;
    foreach (vecs[i]) begin
      @(negedge clk);
      rst          = vecs[i].rst;
      id_valid     = vecs[i].idv;
      mem_stall    = vecs[i].stall;
      flush        = vecs[i].flush;
      id_pc        = vecs[i].f.pc;
      id_rs1_addr  = vecs[i].f.rs1_addr;
      id_rs2_addr  = vecs[i].f.rs2_addr;
      id_rd_addr   = vecs[i].f.rd_addr;
      id_rs1_data  = vecs[i].f.rs1_data;
      id_rs2_data  = vecs[i].f.rs2_data;
      id_imm       = vecs[i].f.imm;
      id_alu_op    = vecs[i].f.alu_op;
      id_mem_read  = vecs[i].f.mem_read;
      id_mem_write = vecs[i].f.mem_write;
      id_reg_write = vecs[i].f.reg_write;
      #1;
      n_chk++;
      if (id_ready !== vecs[i].rdy) begin
        n_fail++;
        $display("FAIL row%0d id_ready: got %b want %b", i, id_ready, vecs[i].rdy);
      end
      case (vecs[i].kind)
        K_CAP:   exp_v = '{valid: 1'b1, f: vecs[i].f};
        K_BUB:   exp_v = '0;
        default: exp_v = last_exp;
      endcase
      last_exp = exp_v;
      sb.push_back(exp_v);

      @(posedge clk);
      #1;
      got = '{valid: ex_valid, f: '{pc: ex_pc, rs1_addr: ex_rs1_addr, rs2_addr: ex_rs2_addr,
              rd_addr: ex_rd_addr, rs1_data: ex_rs1_data, rs2_data: ex_rs2_data, imm: ex_imm,
              alu_op: ex_alu_op, mem_read: ex_mem_read, mem_write: ex_mem_write,
              reg_write: ex_reg_write}};
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL row%0d scoreboard: got empty queue want one entry", i);
      end else begin
        exp_v = sb.pop_front();
        if (got.valid !== exp_v.valid) begin
          n_fail++;
          $display("FAIL row%0d ex_valid: got %b want %b", i, got.valid, exp_v.valid);
        end
        n_chk++;
        if (got.f !== exp_v.f) begin
          n_fail++;
          $display("FAIL row%0d ex_fields: got %h want %h", i, got.f, exp_v.f);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
